// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-deep registered response slot tagged by the winning port.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    logic              last_grant_r;
    logic              out_valid_r;
    logic              out_owner_r;
    logic [DATA_W-1:0] out_data_r;

    logic              grant_s;
    logic              can_accept_s;
    logic              accept_s;

    // Grant selection, slot availability, request handshakes and ALU operand mux.
    always_comb begin
        grant_s      = 1'b0;
        can_accept_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        // The slot may be refilled on the same edge its owner drains it.
        if (!out_valid_r) begin
            can_accept_s = 1'b1;
        end else if (out_owner_r) begin
            can_accept_s = rsp1_ready;
        end else begin
            can_accept_s = rsp0_ready;
        end

        req0_ready = req0_valid & ~grant_s & can_accept_s & ~rst;
        req1_ready = req1_valid &  grant_s & can_accept_s & ~rst;
        accept_s   = req0_ready | req1_ready;

        if (grant_s) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end else begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end
    end

    // Response slot and round-robin history; history moves only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            out_valid_r  <= 1'b0;
            out_owner_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            out_data_r   <= alu_result;
            out_owner_r  <= req1_ready;
            out_valid_r  <= 1'b1;
            last_grant_r <= req1_ready;
        end else if (out_valid_r && (out_owner_r ? rsp1_ready : rsp0_ready)) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign rsp0_valid = out_valid_r & ~out_owner_r;
    assign rsp1_valid = out_valid_r &  out_owner_r;
    assign rsp_result = out_data_r;

endmodule
